// File: rtl/tff_updown_counter_pkg.sv
// Shared constants for the T-flip-flop up/down counter: default sizing and
// direction encoding.
package tff_updown_counter_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_MOD   = 10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : tff_updown_counter_pkg

// File: rtl/tff_updown_counter_tff_bit.sv
// Single T flip-flop with synchronous active-low reset and a synchronous
// load path that takes priority over the toggle input.
module tff_bit (
  input  logic CLK,
  input  logic RSTn,
  input  logic T,
  input  logic LD,
  input  logic LD_VAL,
  output logic Q,
  output logic Qn
);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      Q <= 1'b0;
    end else if (LD) begin
      Q <= LD_VAL;
    end else if (T) begin
      Q <= ~Q;
    end else begin
      Q <= Q;
    end
  end

  // Complement is derived from the stored bit so it tracks Q with no lag.
  assign Qn = ~Q;

endmodule : tff_bit

// File: rtl/tff_updown_counter.sv
// Up/down counter built from WIDTH T flip-flops.
// Optional macro TFF_CNT_MODULO_EN limits the range to 0..MOD-1.
module tff_updown_counter
  import tff_updown_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MOD   = DEF_MOD
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             EN,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             TC
);

  if (WIDTH < 2 || WIDTH > 32 || MOD < 2) begin : g_param_err
    $error("tff_updown_counter: illegal WIDTH/MOD parameters");
  end

`ifdef TFF_CNT_MODULO_EN
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
`else
  localparam logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}};
`endif

  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] ld_val;
  logic             ld;

`ifdef TFF_CNT_MODULO_EN
  // Wraps are forced through the load path; an explicit LOAD still wins.
  always_comb begin
    ld     = 1'b0;
    ld_val = D;
    if (LOAD) begin
      ld = 1'b1;
      if ({1'b0, D} >= MOD_EXT) begin
        ld_val = {WIDTH{1'b0}};
      end else begin
        ld_val = D;
      end
    end else if (EN && (UP == DIR_UP) && (Q == MAX_CNT)) begin
      ld     = 1'b1;
      ld_val = {WIDTH{1'b0}};
    end else if (EN && (UP == DIR_DOWN) && (Q == {WIDTH{1'b0}})) begin
      ld     = 1'b1;
      ld_val = MAX_CNT;
    end else begin
      ld     = 1'b0;
      ld_val = D;
    end
  end
`else
  assign ld     = LOAD;
  assign ld_val = D;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign tog[i] = EN;
    end else begin : g_upper
      // Toggle when every lower bit is at its carry (up) or borrow (down) state.
      assign tog[i] = EN & ((UP == DIR_UP) ? (&Q[i-1:0]) : (~|Q[i-1:0]));
    end

    tff_bit u_bit (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .T      (tog[i]),
      .LD     (ld),
      .LD_VAL (ld_val[i]),
      .Q      (Q[i]),
      .Qn     (Qn[i])
    );
  end

  // Terminal count looks only at EN, direction and the current count.
  always_comb begin
    TC = 1'b0;
    if (EN) begin
      if (UP == DIR_UP) begin
        TC = (Q == MAX_CNT);
      end else begin
        TC = (Q == {WIDTH{1'b0}});
      end
    end else begin
      TC = 1'b0;
    end
  end

endmodule : tff_updown_counter

// File: tb/tb_tff_updown_counter.sv
// Directed self-checking bench for tff_updown_counter (WIDTH=4, MOD=10).
// Honors TFF_CNT_MODULO_EN to select the matching vector set.
module tb_tff_updown_counter;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] qn;
  logic       tc;

  int n_checks = 0;
  int n_pass   = 0;

  tff_updown_counter #(.WIDTH(4), .MOD(10)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .EN   (en),
    .UP   (up),
    .LOAD (load),
    .D    (d),
    .Q    (q),
    .Qn   (qn),
    .TC   (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input logic [3:0] exp_q, input logic exp_tc);
    check({tag, ".q"},  {28'd0, q},  {28'd0, exp_q});
    check({tag, ".qn"}, {28'd0, qn}, {28'd0, ~exp_q});
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, exp_tc});
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd5;
    #2;
    // Reset wins over LOAD and EN.
    step();
    step();
    check_q("reset", 4'd0, 1'b0);
    up = 1'b0; #1;
    check("reset_tc_down", {31'd0, tc}, 32'd1);

`ifndef TFF_CNT_MODULO_EN
    // Up count through binary wrap.
    rstn = 1'b1; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      check_q($sformatf("up%0d", k), 4'(k % 16), (k % 16) == 15);
    end

    // Load 3, count down through zero, then hold.
    load = 1'b1; d = 4'd3; en = 1'b0;
    step();
    check_q("ld3", 4'd3, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b0; #1;
    begin
      logic [3:0] exp_dn [4];
      exp_dn = '{4'd2, 4'd1, 4'd0, 4'd15};
      for (int k = 0; k < 4; k++) begin
        step();
        check_q($sformatf("dn%0d", k), exp_dn[k], exp_dn[k] == 4'd0);
      end
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up = ~up;
      step();
      check_q($sformatf("hold%0d", k), 4'd15, 1'b0);
    end

    // TC ignores LOAD: Q=15, up, EN=1 with LOAD pending.
    en = 1'b1; up = 1'b1; load = 1'b1; d = 4'd9; #1;
    check("tc_with_load", {31'd0, tc}, 32'd1);
    // LOAD beats EN.
    step();
    check_q("prio_load", 4'd9, 1'b0);
    // Same-edge direction change.
    load = 1'b0; up = 1'b0;
    step();
    check("dir_dn", {28'd0, q}, 32'd8);
    up = 1'b1;
    step();
    check("dir_up", {28'd0, q}, 32'd9);
    // Reset beats LOAD mid-count.
    rstn = 1'b0; load = 1'b1; d = 4'd7;
    step();
    check_q("prio_rst", 4'd0, 1'b0);
`else
    // Modulo up wrap at MOD-1.
    rstn = 1'b1; load = 1'b1; d = 4'd8; en = 1'b0; up = 1'b1;
    step();
    check_q("m_ld8", 4'd8, 1'b0);
    load = 1'b0; en = 1'b1; #1;
    step();
    check_q("m_up9", 4'd9, 1'b1);
    step();
    check_q("m_wrap0", 4'd0, 1'b0);
    step();
    check_q("m_up1", 4'd1, 1'b0);
    // Out-of-range load clamps to zero.
    load = 1'b1; d = 4'd12; en = 1'b0;
    step();
    check_q("m_ld12", 4'd0, 1'b0);
    // Down from zero wraps to MOD-1, then flip direction.
    load = 1'b0; en = 1'b1; up = 1'b0; #1;
    check("m_tc_dn", {31'd0, tc}, 32'd1);
    step();
    check_q("m_dnwrap", 4'd9, 1'b0);
    up = 1'b1; #1;
    check("m_tc_up9", {31'd0, tc}, 32'd1);
    step();
    check_q("m_flip0", 4'd0, 1'b0);
    // In-range load is taken as-is; LOAD beats a pending wrap.
    load = 1'b1; d = 4'd9;
    step();
    check_q("m_ld9", 4'd9, 1'b1);
    d = 4'd5;
    step();
    check_q("m_ld5", 4'd5, 1'b0);
    rstn = 1'b0;
    step();
    check_q("m_rst", 4'd0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tff_updown_counter

// File: doc/tff_updown_counter.md
TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits (legal range 2..32).
REQ-002 Parameter: MOD, 10, modulo limit; used only when TFF_CNT_MODULO_EN is defined; legal range 2..2**WIDTH.
REQ-003 CLK  input  1  rising-edge clock; one clock domain only.
REQ-004 RSTn  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  count enable; acts as the global T input; 1 means count this cycle.
REQ-006 UP  input  1  direction: 1 counts up, 0 counts down.
REQ-007 LOAD  input  1  parallel-load strobe.
REQ-008 D  input  WIDTH  parallel-load value.
REQ-009 Q  output  WIDTH  count value.
REQ-010 Qn  output  WIDTH  bitwise complement of Q.
REQ-011 TC  output  1  terminal count, combinational; asserted when EN=1 and Q is at the terminal value for the current direction.

Function
REQ-012 Each bit of Q SHALL be a T flip-flop: bit i toggles on a rising CLK edge when its toggle term is 1, and holds otherwise.
REQ-013 Up-counting toggle term for bit i: EN AND Q[i-1:0] all ones. Bit 0 uses EN alone.
REQ-014 Down-counting toggle term for bit i: EN AND Q[i-1:0] all zeros. Bit 0 uses EN alone.
REQ-015 Priority on each edge: RSTn=0 first, then LOAD=1, then EN=1, then hold.
REQ-016 LOAD=1 SHALL set Q to D on the next edge, regardless of EN and UP. Latency is one cycle.
REQ-017 EN=0 with LOAD=0 SHALL hold Q. UP changes have no effect while EN=0.
REQ-018 Without the macro, wrap is binary: up from 2**WIDTH-1 goes to 0; down from 0 goes to 2**WIDTH-1.
REQ-019 TC terminal value: up, Q equals the maximum count; down, Q equals 0. TC SHALL NOT depend on LOAD.
REQ-020 Qn SHALL equal ~Q at all times, including during reset, with no extra cycle of latency.
REQ-021 A change of UP in the same cycle as EN=1 SHALL take effect on that edge. There is no direction-change pipeline.

Reset
REQ-022 RSTn=0 sampled at a rising CLK edge SHALL set Q=0 and Qn=all ones. TC then follows REQ-019.
REQ-023 Reset asserted mid-count or coincident with LOAD SHALL win; the count in progress is discarded.
REQ-024 Before the first reset edge, Q is undefined. Only the first edge with RSTn=0 makes Q defined.

Configuration
REQ-025 Macro TFF_CNT_MODULO_EN:
- Defined: the count range SHALL be 0..MOD-1. Up from MOD-1 goes to 0. Down from 0 goes to MOD-1. TC-up fires at Q=MOD-1.
- Defined: a LOAD with D>=MOD SHALL load 0.
- Not defined: MOD is ignored and REQ-018 applies. The modulo compare logic SHALL NOT be synthesised.

Structure
REQ-026 A shared package SHALL hold:
- the default WIDTH and MOD constants;
- the direction encoding constants DIR_UP=1 and DIR_DOWN=0.
REQ-027 One sub-module, tff_bit, SHALL be used:
- ports CLK, RSTn, T, LD, LD_VAL, Q, Qn;
- a synchronous active-low reset;
- instantiated WIDTH times by a generate loop.
REQ-028 Modulo wrap SHALL be implemented as a synchronous load of the wrap value through the LD path of tff_bit.

Verification (WIDTH=4; MOD=10 when the macro is on)
REQ-029 Reset: RSTn=0 for 2 edges with EN=1 and LOAD=1 -> Q=0, Qn=4'hF.
REQ-030 Up count, no macro: EN=1, UP=1 for 17 edges from 0 -> Q steps 1..15, 0, 1. TC=1 only while Q=15.
REQ-031 Down count and hold: load D=3, then EN=1, UP=0 for 4 edges, then EN=0 for 3 edges -> Q=2,1,0,15 then holds at 15. TC=1 only while Q=0 with EN=1.
REQ-032 Priority: LOAD=1, D=9 together with EN=1, UP=1 -> Q=9 (not 10). RSTn=0 on the following edge -> Q=0.
REQ-033 Macro on, up: EN=1, UP=1 from Q=8 -> Q=9, then 0. TC=1 at Q=9. Load D=12 -> Q=0.
REQ-034 Macro on, down with direction flip: from Q=0, EN=1, UP=0 -> Q=9. Then UP=1 on the next edge -> Q=0.
